// File: rtl/sm3_ahb_regbank.sv
// AHB-lite register bank for NUM_CH SM3 channels: control, DMA fields, status, digest, interrupt (IMR when SM3_REGBANK_IRQ_MASK_EN).
// Latency: zero wait states; read data registered at end of address phase, writes applied at end of data phase.
// Backpressure: none, AHB_HREADYOUT tied high and AHB_HRESP tied OKAY.
module sm3_ahb_regbank #(
   parameter int NUM_CH = 2,
   parameter int DMA_AW = 13,
   parameter int ADDR_W = 20
) (
   input  logic                     AHB_HCLK,
   input  logic                     AHB_HRESETN,
   input  logic                     AHB_HSEL,
   input  logic [1:0]               AHB_HTRANS,
   input  logic                     AHB_HREADY,
   input  logic                     AHB_HWRITE,
   input  logic [ADDR_W-1:0]        AHB_HADDR,
   input  logic [31:0]              AHB_HWDATA,
   output logic [31:0]              AHB_HRDATA,
   output logic                     AHB_HREADYOUT,
   output logic                     AHB_HRESP,
   output logic [NUM_CH-1:0]        CH_ENABLE,
   output logic [2*NUM_CH-1:0]      CH_CMDR,
   output logic [DMA_AW*NUM_CH-1:0] CH_SAR,
   output logic [DMA_AW*NUM_CH-1:0] CH_DAR,
   output logic [DMA_AW*NUM_CH-1:0] CH_BSR,
   input  logic [NUM_CH-1:0]        CH_DONE,
   input  logic [256*NUM_CH-1:0]    CH_TEMP_RES,
   output logic                     CRYPT_INTR
);

   localparam logic [ADDR_W-1:0] ISR_ADDR = ADDR_W'(12'h100);
   localparam logic [ADDR_W-1:0] IMR_ADDR = ADDR_W'(12'h101);
   localparam logic [ADDR_W-1:0] ID_ADDR  = ADDR_W'(12'h102);

   logic                accept;
   logic                dp_wr;
   logic [ADDR_W-1:0]   dp_addr;

   logic [1:0]          cmdr_q   [NUM_CH];
   logic [1:0]          cmdr_nxt [NUM_CH];
   logic [DMA_AW-1:0]   sar_q    [NUM_CH];
   logic [DMA_AW-1:0]   sar_nxt  [NUM_CH];
   logic [DMA_AW-1:0]   dar_q    [NUM_CH];
   logic [DMA_AW-1:0]   dar_nxt  [NUM_CH];
   logic [DMA_AW-1:0]   bsr_q    [NUM_CH];
   logic [DMA_AW-1:0]   bsr_nxt  [NUM_CH];
   logic [255:0]        digest_q   [NUM_CH];
   logic [255:0]        digest_nxt [NUM_CH];
   logic [NUM_CH-1:0]   busy_q, busy_nxt, done_q, done_nxt, err_q, err_nxt;
   logic [NUM_CH-1:0]   en_nxt, ch_enable_q;
   logic [NUM_CH-1:0]   isr_q, isr_nxt;
   logic                crypt_intr_q;
   logic [31:0]         hrdata_q, hrdata_nxt;

   logic                wr_ch_hit, rd_ch_hit;
   logic [1:0]          wr_ch, rd_ch;
   logic [3:0]          wr_off, rd_off;
   logic                unused_sink;

   assign accept    = AHB_HSEL & AHB_HTRANS[1] & AHB_HREADY;
   assign wr_ch     = dp_addr[5:4];
   assign wr_off    = dp_addr[3:0];
   assign rd_ch     = AHB_HADDR[5:4];
   assign rd_off    = AHB_HADDR[3:0];
   // Channel windows occupy word addresses 0x00..0x3F; windows beyond NUM_CH decode to nothing.
   assign wr_ch_hit = dp_wr && (dp_addr[ADDR_W-1:6] == '0) && (int'(wr_ch) < NUM_CH);
   assign rd_ch_hit = accept && !AHB_HWRITE && (AHB_HADDR[ADDR_W-1:6] == '0) && (int'(rd_ch) < NUM_CH);
   assign unused_sink = ^{AHB_HTRANS[0], AHB_HWDATA};

`ifdef SM3_REGBANK_IRQ_MASK_EN
   logic [NUM_CH-1:0]   imr_q, imr_nxt;
   logic                irq_raw;

   // IMR next value: plain read/write register.
   always_comb begin
      imr_nxt = imr_q;
      if (dp_wr && dp_addr == IMR_ADDR) imr_nxt = AHB_HWDATA[NUM_CH-1:0];
   end

   // IMR state register.
   always_ff @(posedge AHB_HCLK or negedge AHB_HRESETN) begin
      if (!AHB_HRESETN) imr_q <= '0;
      else              imr_q <= imr_nxt;
   end

   assign irq_raw = |(isr_q & imr_q);
`else
   logic                irq_raw;
   assign irq_raw = |isr_q;
`endif

   // Next-state for channel registers and ISR; done-set is applied after W1C so it wins.
   always_comb begin
      isr_nxt = isr_q;
      if (dp_wr && dp_addr == ISR_ADDR) isr_nxt = isr_q & ~AHB_HWDATA[NUM_CH-1:0];
      busy_nxt = busy_q;
      done_nxt = done_q;
      err_nxt  = err_q;
      en_nxt   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         cmdr_nxt[c]   = cmdr_q[c];
         sar_nxt[c]    = sar_q[c];
         dar_nxt[c]    = dar_q[c];
         bsr_nxt[c]    = bsr_q[c];
         digest_nxt[c] = digest_q[c];
         if (wr_ch_hit && wr_ch == 2'(c)) begin
            case (wr_off)
               4'd0: begin
                  cmdr_nxt[c] = AHB_HWDATA[2:1];
                  if (AHB_HWDATA[0]) begin
                     if (busy_q[c]) begin
                        err_nxt[c] = 1'b1;
                     end else begin
                        en_nxt[c]   = 1'b1;
                        busy_nxt[c] = 1'b1;
                        done_nxt[c] = 1'b0;
                        err_nxt[c]  = 1'b0;
                     end
                  end
               end
               4'd1:    sar_nxt[c] = AHB_HWDATA[DMA_AW-1:0];
               4'd2:    dar_nxt[c] = AHB_HWDATA[DMA_AW-1:0];
               4'd3:    bsr_nxt[c] = AHB_HWDATA[DMA_AW-1:0];
               default: ;
            endcase
         end
         if (CH_DONE[c] && busy_q[c]) begin
            digest_nxt[c] = CH_TEMP_RES[256*c +: 256];
            busy_nxt[c]   = 1'b0;
            done_nxt[c]   = 1'b1;
            isr_nxt[c]    = 1'b1;
         end
      end
   end

   // Read mux sees next-state values so a read right behind a write returns the new data.
   always_comb begin
      hrdata_nxt = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (rd_ch_hit && rd_ch == 2'(c)) begin
            case (rd_off)
               4'd0:    hrdata_nxt = {29'd0, cmdr_nxt[c], 1'b0};
               4'd1:    hrdata_nxt = 32'(sar_nxt[c]);
               4'd2:    hrdata_nxt = 32'(dar_nxt[c]);
               4'd3:    hrdata_nxt = 32'(bsr_nxt[c]);
               4'd4:    hrdata_nxt = {29'd0, err_nxt[c], done_nxt[c], busy_nxt[c]};
               default: if (rd_off[3]) hrdata_nxt = digest_nxt[c][{~rd_off[2:0], 5'd0} +: 32];
            endcase
         end
      end
      if (accept && !AHB_HWRITE) begin
         if (AHB_HADDR == ISR_ADDR) hrdata_nxt = 32'(isr_nxt);
`ifdef SM3_REGBANK_IRQ_MASK_EN
         if (AHB_HADDR == IMR_ADDR) hrdata_nxt = 32'(imr_nxt);
`endif
         if (AHB_HADDR == ID_ADDR)  hrdata_nxt = {16'h53A3, 8'h00, 8'(NUM_CH)};
      end
   end

   // Bus pipeline, channel state, ISR and interrupt output registers.
   always_ff @(posedge AHB_HCLK or negedge AHB_HRESETN) begin
      if (!AHB_HRESETN) begin
         dp_wr        <= 1'b0;
         dp_addr      <= '0;
         hrdata_q     <= '0;
         ch_enable_q  <= '0;
         busy_q       <= '0;
         done_q       <= '0;
         err_q        <= '0;
         isr_q        <= '0;
         crypt_intr_q <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            cmdr_q[c]   <= '0;
            sar_q[c]    <= '0;
            dar_q[c]    <= '0;
            bsr_q[c]    <= '0;
            digest_q[c] <= '0;
         end
      end else begin
         dp_wr        <= accept & AHB_HWRITE;
         if (accept) dp_addr <= AHB_HADDR;
         hrdata_q     <= hrdata_nxt;
         ch_enable_q  <= en_nxt;
         busy_q       <= busy_nxt;
         done_q       <= done_nxt;
         err_q        <= err_nxt;
         isr_q        <= isr_nxt;
         crypt_intr_q <= irq_raw;
         for (int c = 0; c < NUM_CH; c++) begin
            cmdr_q[c]   <= cmdr_nxt[c];
            sar_q[c]    <= sar_nxt[c];
            dar_q[c]    <= dar_nxt[c];
            bsr_q[c]    <= bsr_nxt[c];
            digest_q[c] <= digest_nxt[c];
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
      assign CH_CMDR[2*g +: 2]         = cmdr_q[g];
      assign CH_SAR[DMA_AW*g +: DMA_AW] = sar_q[g];
      assign CH_DAR[DMA_AW*g +: DMA_AW] = dar_q[g];
      assign CH_BSR[DMA_AW*g +: DMA_AW] = bsr_q[g];
   end

   assign CH_ENABLE     = ch_enable_q;
   assign CRYPT_INTR    = crypt_intr_q;
   assign AHB_HRDATA    = hrdata_q;
   assign AHB_HREADYOUT = 1'b1;
   assign AHB_HRESP     = 1'b0;

endmodule

// File: tb/tb_sm3_ahb_regbank.sv
// Bench for sm3_ahb_regbank: directed AHB transfers against a register-level model.
// Latency: model expects read data one cycle after address phase, enable pulse one cycle after data phase.
// Backpressure: none exercised; HREADY held high.
`timescale 1ns/1ps
module tb_sm3_ahb_regbank;
   localparam int NCH = 2;
   localparam int AW  = 13;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 hsel, hready, hwrite;
   logic [1:0]           htrans;
   logic [19:0]          haddr;
   logic [31:0]          hwdata;
   logic [31:0]          hrdata;
   logic                 hreadyout, hresp;
   logic [NCH-1:0]       ch_enable;
   logic [2*NCH-1:0]     ch_cmdr;
   logic [AW*NCH-1:0]    ch_sar, ch_dar, ch_bsr;
   logic [NCH-1:0]       ch_done;
   logic [256*NCH-1:0]   temp_res;
   logic                 crypt_intr;

   always #5 clk = ~clk;

   sm3_ahb_regbank #(.NUM_CH(NCH), .DMA_AW(AW), .ADDR_W(20)) dut (
      .AHB_HCLK(clk), .AHB_HRESETN(rst_n), .AHB_HSEL(hsel), .AHB_HTRANS(htrans),
      .AHB_HREADY(hready), .AHB_HWRITE(hwrite), .AHB_HADDR(haddr), .AHB_HWDATA(hwdata),
      .AHB_HRDATA(hrdata), .AHB_HREADYOUT(hreadyout), .AHB_HRESP(hresp),
      .CH_ENABLE(ch_enable), .CH_CMDR(ch_cmdr), .CH_SAR(ch_sar), .CH_DAR(ch_dar),
      .CH_BSR(ch_bsr), .CH_DONE(ch_done), .CH_TEMP_RES(temp_res), .CRYPT_INTR(crypt_intr)
   );

   // Register-level model of the bank.
   logic [1:0]    m_cmdr [NCH];
   logic [AW-1:0] m_sar  [NCH];
   logic [AW-1:0] m_dar  [NCH];
   logic [AW-1:0] m_bsr  [NCH];
   logic          m_busy [NCH];
   logic          m_done [NCH];
   logic          m_err  [NCH];
   logic [255:0]  m_dig  [NCH];
   logic [NCH-1:0] m_isr, m_imr;
   logic [NCH-1:0] exp_en;
   logic [31:0]   exp_rdata;
   logic          intr_prev = 1'b0;
   logic [NCH-1:0] en_seen;
   logic [255:0]  res_a, res_b;
   int            total = 0;
   int            bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_cmdr[c] = '0; m_sar[c] = '0; m_dar[c] = '0; m_bsr[c] = '0;
         m_busy[c] = 1'b0; m_done[c] = 1'b0; m_err[c] = 1'b0; m_dig[c] = '0;
      end
      m_isr = '0; m_imr = '0; exp_en = '0; exp_rdata = '0;
   endtask

   task automatic model_write(input int addr, input logic [31:0] d);
      int c, o;
      if (addr < 16*NCH) begin
         c = addr / 16;
         o = addr % 16;
         if (o == 0) begin
            m_cmdr[c] = d[2:1];
            if (d[0]) begin
               if (m_busy[c]) m_err[c] = 1'b1;
               else begin
                  m_busy[c] = 1'b1; m_done[c] = 1'b0; m_err[c] = 1'b0; exp_en[c] = 1'b1;
               end
            end
         end
         else if (o == 1) m_sar[c] = d[AW-1:0];
         else if (o == 2) m_dar[c] = d[AW-1:0];
         else if (o == 3) m_bsr[c] = d[AW-1:0];
      end
      else if (addr == 256) m_isr = m_isr & ~d[NCH-1:0];
`ifdef SM3_REGBANK_IRQ_MASK_EN
      else if (addr == 257) m_imr = d[NCH-1:0];
`endif
   endtask

   task automatic model_done(input int c, input logic [255:0] r);
      if (m_busy[c]) begin
         m_dig[c] = r; m_busy[c] = 1'b0; m_done[c] = 1'b1; m_isr[c] = 1'b1;
      end
   endtask

   function automatic logic [31:0] model_read(input int addr);
      int c, o;
      model_read = '0;
      if (addr < 16*NCH) begin
         c = addr / 16;
         o = addr % 16;
         if (o == 0)      model_read = {29'd0, m_cmdr[c], 1'b0};
         else if (o == 1) model_read = 32'(m_sar[c]);
         else if (o == 2) model_read = 32'(m_dar[c]);
         else if (o == 3) model_read = 32'(m_bsr[c]);
         else if (o == 4) model_read = {29'd0, m_err[c], m_done[c], m_busy[c]};
         else if (o >= 8) model_read = m_dig[c][255-32*(o-8) -: 32];
      end
      else if (addr == 256) model_read = 32'(m_isr);
`ifdef SM3_REGBANK_IRQ_MASK_EN
      else if (addr == 257) model_read = 32'(m_imr);
`endif
      else if (addr == 258) model_read = {16'h53A3, 8'h00, 8'(NCH)};
   endfunction

   function automatic logic model_intr();
`ifdef SM3_REGBANK_IRQ_MASK_EN
      return |(m_isr & m_imr);
`else
      return |m_isr;
`endif
   endfunction

   // Every cycle: all outputs against the model; interrupt lags the model ISR/IMR by one cycle.
   always @(negedge clk) begin
      chk("hreadyout", 64'(hreadyout), 64'(1'b1));
      chk("hresp", 64'(hresp), 64'(1'b0));
      chk("ch_enable", 64'(ch_enable), 64'(exp_en));
      chk("ch_cmdr", 64'(ch_cmdr), 64'({m_cmdr[1], m_cmdr[0]}));
      chk("ch_sar", 64'(ch_sar), 64'({m_sar[1], m_sar[0]}));
      chk("ch_dar", 64'(ch_dar), 64'({m_dar[1], m_dar[0]}));
      chk("ch_bsr", 64'(ch_bsr), 64'({m_bsr[1], m_bsr[0]}));
      chk("hrdata", 64'(hrdata), 64'(exp_rdata));
      chk("crypt_intr", 64'(crypt_intr), 64'(rst_n ? intr_prev : 1'b0));
      intr_prev = rst_n ? model_intr() : 1'b0;
   end

   task automatic bus_write(input int addr, input logic [31:0] d);
      @(posedge clk) #1;
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 20'(addr);
      @(posedge clk) #1;
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = d;
      @(posedge clk) #1;
      model_write(addr, d);
      @(negedge clk) en_seen = ch_enable;
      @(posedge clk) #1;
      exp_en = '0;
   endtask

   task automatic bus_read(input string nm, input int addr, input logic [31:0] lit);
      @(posedge clk) #1;
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 20'(addr);
      @(posedge clk) #1;
      hsel = 1'b0; htrans = 2'b00;
      exp_rdata = model_read(addr);
      @(negedge clk) chk(nm, 64'(hrdata), 64'(lit));
      @(posedge clk) #1;
      exp_rdata = '0;
   endtask

   task automatic bus_done(input int c, input logic [255:0] r);
      @(posedge clk) #1;
      ch_done[c] = 1'b1; temp_res[256*c +: 256] = r;
      @(posedge clk) #1;
      ch_done = '0;
      model_done(c, r);
   endtask

   initial begin
      rst_n = 1'b0; hsel = 1'b0; htrans = 2'b00; hready = 1'b1; hwrite = 1'b0;
      haddr = '0; hwdata = '0; ch_done = '0; temp_res = '0; en_seen = '0;
      model_reset();
      for (int k = 0; k < 8; k++) begin
         res_a[255-32*k -: 32] = 32'h11111111 * 32'(k);
         res_b[255-32*k -: 32] = 32'hA0000000 + 32'(k);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_hrdata", 64'(hrdata), 64'd0);
      chk("rst_enable", 64'(ch_enable), 64'd0);
      chk("rst_intr", 64'(crypt_intr), 64'd0);
      @(posedge clk) #1 rst_n = 1'b1;
      bus_read("rst_sar0", 1, 32'h0);

      // DMA fields: store low 13 bits only.
      bus_write(1, 32'h1FFF);
      bus_write(2, 32'h0010);
      bus_write(3, 32'h0100);
      bus_read("sar0", 1, 32'h1FFF);
      bus_read("dar0", 2, 32'h0010);
      bus_read("bsr0", 3, 32'h0100);
      bus_write(1, 32'hFFFFFFFF);
      bus_read("sar0_trunc", 1, 32'h00001FFF);

      // Start channel 1, then a second start while busy.
      bus_write(16, 32'h5);
      chk("start1_pulse", 64'(en_seen), 64'(2'b10));
      chk("start1_cmdr", 64'(ch_cmdr[3:2]), 64'(2'b10));
      bus_read("status1_busy", 20, 32'h1);
      bus_write(16, 32'h5);
      chk("restart1_nopulse", 64'(en_seen), 64'(2'b00));
      bus_read("status1_err", 20, 32'h5);
      bus_write(20, 32'h0);
      bus_read("status1_ro", 20, 32'h5);

      // Channel 0 run to completion, digest capture and interrupt.
      bus_write(0, 32'h1);
      chk("start0_pulse", 64'(en_seen), 64'(2'b01));
      bus_done(0, res_a);
      for (int k = 0; k < 8; k++) bus_read("digest0", 8 + k, 32'h11111111 * 32'(k));
      bus_read("status0_done", 4, 32'h2);
      bus_read("isr", 256, 32'h1);
`ifdef SM3_REGBANK_IRQ_MASK_EN
      chk("intr_masked", 64'(crypt_intr), 64'd0);
      bus_write(257, 32'h1);
      bus_read("imr", 257, 32'h1);
      chk("intr_unmasked", 64'(crypt_intr), 64'd1);
`else
      chk("intr_nomask", 64'(crypt_intr), 64'd1);
      bus_write(257, 32'h1);
      bus_read("imr_absent", 257, 32'h0);
`endif

      // Done while idle is ignored.
      bus_done(0, res_b);
      bus_read("digest0_keep", 15, 32'h77777777);

      // W1C of ISR in the same cycle as a new done: set wins.
      bus_write(256, 32'h1);
      bus_read("isr_cleared", 256, 32'h0);
      bus_write(0, 32'h1);
      @(posedge clk) #1;
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 20'h100;
      @(posedge clk) #1;
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h1;
      ch_done[0] = 1'b1; temp_res[255:0] = res_b;
      @(posedge clk) #1;
      ch_done = '0;
      model_write(256, 32'h1);
      model_done(0, res_b);
      bus_read("isr_set_wins", 256, 32'h1);
      bus_read("digest0_new", 8, 32'hA0000000);

      // Write immediately followed by a read of the same register.
      @(posedge clk) #1;
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 20'h12;
      @(posedge clk) #1;
      hwrite = 1'b0; hwdata = 32'h0ABC;
      @(posedge clk) #1;
      hsel = 1'b0; htrans = 2'b00;
      model_write(18, 32'h0ABC);
      exp_rdata = model_read(18);
      @(negedge clk) chk("b2b_read", 64'(hrdata), 64'h0ABC);
      @(posedge clk) #1;
      exp_rdata = '0;

      // ID, absent channel window, unmapped holes.
      bus_read("id", 258, 32'h53A30002);
      bus_write(49, 32'h123);
      bus_read("ch3_sar", 49, 32'h0);
      bus_read("ch3_ctrl", 48, 32'h0);
      bus_read("unmapped", 259, 32'h0);
      bus_read("hole", 5, 32'h0);

      // Reset during a write data phase discards the write.
      @(posedge clk) #1;
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 20'h13;
      @(posedge clk) #1;
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h55;
      #2;
      rst_n = 1'b0;
      model_reset();
      @(posedge clk) #1;
      @(posedge clk) #1;
      rst_n = 1'b1;
      bus_read("bsr1_after_rst", 19, 32'h0);
      bus_write(1, 32'h0042);
      bus_read("sar0_after_rst", 1, 32'h0042);
      bus_read("isr_after_rst", 256, 32'h0);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sm3_ahb_regbank.md
SM3_AHB_REGBANK -- requirements
Module: sm3_ahb_regbank

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent SM3 channels (1..4).
REQ-002 SHALL have parameter DMA_AW, default 13, width of source/destination address and block-size fields.
REQ-003 SHALL have parameter ADDR_W, default 20, AHB word-address width.
REQ-004 SHALL have ports: AHB_HCLK in 1 clock; AHB_HRESETN in 1 asynchronous active-low reset.
REQ-005 SHALL have ports: AHB_HSEL in 1; AHB_HTRANS in 2; AHB_HREADY in 1; AHB_HWRITE in 1; AHB_HADDR in ADDR_W (word address); AHB_HWDATA in 32.
REQ-006 SHALL have ports: AHB_HRDATA out 32; AHB_HREADYOUT out 1; AHB_HRESP out 1.
REQ-007 SHALL have per-channel flat ports: CH_ENABLE out NUM_CH start pulse; CH_CMDR out 2*NUM_CH; CH_SAR out DMA_AW*NUM_CH; CH_DAR out DMA_AW*NUM_CH; CH_BSR out DMA_AW*NUM_CH; CH_DONE in NUM_CH; CH_TEMP_RES in 256*NUM_CH; CRYPT_INTR out 1.

Function
REQ-008 SHALL accept a transfer when AHB_HSEL & AHB_HTRANS[1] & AHB_HREADY at a rising edge; address/direction registered; write data taken from AHB_HWDATA in the following (data-phase) cycle.
REQ-009 SHALL drive AHB_HREADYOUT=1 and AHB_HRESP=0 always (zero wait states).
REQ-010 SHALL present read data on AHB_HRDATA during the data phase (registered at end of address phase); AHB_HRDATA=0 outside read data phases.
REQ-011 SHALL map channel c at word base 16*c: +0 CTRL (bit0 START write-only, bits2:1 CMDR), +1 SAR, +2 DAR, +3 BSR, +4 STATUS (bit0 BUSY, bit1 DONE, bit2 ERR; read-only), +8..+15 DIGEST word 0..7 (read-only, word 0 = TEMP_RES[255:224]).
REQ-012 SHALL map globals at word 0x100: ISR (bit c = channel c done, write-1-to-clear), 0x101 IMR, 0x102 ID = {16'h53A3, 8'h00, NUM_CH[7:0]} read-only.
REQ-013 SHALL read 0 from unmapped addresses and channels >= NUM_CH; writes there and to read-only fields SHALL be ignored.
REQ-014 SHALL, on write to CTRL with START=1 while BUSY=0, pulse CH_ENABLE[c] high for exactly one cycle after the data phase and set BUSY, clear DONE and ERR.
REQ-015 SHALL, on START while BUSY=1, not pulse CH_ENABLE and set sticky ERR; CMDR update still applies.
REQ-016 SHALL, on CH_DONE[c] high while BUSY, capture CH_TEMP_RES slice c into DIGEST, clear BUSY, set DONE and ISR[c]; CH_DONE while not BUSY SHALL be ignored.
REQ-017 SHALL give ISR set priority over a simultaneous W1C of the same bit.
REQ-018 SHALL drive CRYPT_INTR registered = |(ISR & IMR), one cycle after ISR/IMR change.
REQ-019 SHALL hold SAR/DAR/BSR/CMDR outputs stable from registers, writable regardless of BUSY; only low DMA_AW bits stored, upper bits read 0.
REQ-020 SHALL allow back-to-back transfers: a read immediately following a write to the same address returns the new value.

Reset
REQ-021 SHALL, on AHB_HRESETN low, asynchronously clear all registers, DIGEST, ISR, IMR, pending data phase, CH_ENABLE, CRYPT_INTR and AHB_HRDATA to 0.
REQ-022 SHALL, when reset asserts mid-transfer, discard the pending write; first transfer after release is decoded normally.

Configuration
REQ-023 SHALL support macro SM3_REGBANK_IRQ_MASK_EN: defined -> IMR implemented as above, reset 0; undefined -> IMR absent (reads 0, writes ignored) and CRYPT_INTR = |ISR.

Verification
REQ-024 SHALL cover: write SAR ch0=0x1FFF, DAR=0x0010, BSR=0x0100, read back -> 0x1FFF/0x0010/0x0100; write 0xFFFFFFFF to SAR -> reads 0x00001FFF.
REQ-025 SHALL cover: CTRL ch1 write 0x5 -> CH_ENABLE[1] single-cycle pulse, CH_CMDR[3:2]=2'b10, STATUS=0x1; repeat START -> no pulse, STATUS=0x5.
REQ-026 SHALL cover: CH_DONE[0] with TEMP_RES 0x00000000_11111111_..._77777777 -> DIGEST words read 0x00000000..0x77777777, STATUS=0x2, ISR=0x1; IMR=0x1 -> CRYPT_INTR=1.
REQ-027 SHALL cover: ISR W1C of bit0 in same cycle as new CH_DONE[0] -> ISR bit0 remains 1.
REQ-028 SHALL cover: reads of 0x102 -> 0x53A30002; channel 3 window with NUM_CH=2 -> 0; reset asserted during write data phase -> register stays 0.
REQ-029 SHALL cover both builds of SM3_REGBANK_IRQ_MASK_EN: undefined -> IMR reads 0 and CRYPT_INTR follows ISR.
